// File: rtl/y_alu.sv
// Registered integer ALU: AND, OR, ADD, SUB and unsigned set-less-than.
// One clock of latency from a/b/op to the z result and ex zero flag.
module y_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] z,
  output logic             ex
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // No handshake: a new operation is accepted on every rising edge and its
  // result is visible on z/ex right after that edge; rst wins over any op.

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic             lt;
  logic [WIDTH-1:0] r;

  // Shared adder: op[2] selects a + ~b + 1 for both SUB and SLT.
  assign sub   = op[2];
  assign b_eff = sub ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign carry = sum[WIDTH];
  // Carry-out of a + ~b + 1 is set exactly when a >= b (unsigned).
  assign lt    = ~carry;

  always_comb begin
    r = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD:  r = sum[WIDTH-1:0];
      OP_SUB:  r = sum[WIDTH-1:0];
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, lt};
      default: r = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z  <= '0;
      ex <= 1'b1;
    end else begin
      z  <= r;
      ex <= (r == '0);
    end
  end

endmodule

// File: tb/tb_y_alu.sv
// Directed-vector and random bench for y_alu; results sampled 1 time unit
// after the rising edge that loads them.
module tb_y_alu;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic [W-1:0] z;
  logic         ex;

  int n_checks;
  int n_fail;

  logic [W:0] exp_q[$];

  y_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .op  (op),
    .z   (z),
    .ex  (ex)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         rst;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_z;
    logic         exp_ex;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [W-1:0] exp_z, input logic exp_ex);
    n_checks++;
    if (z !== exp_z || ex !== exp_ex) begin
      n_fail++;
      $display("FAIL %s: got z=%h ex=%b, expected z=%h ex=%b", name, z, ex, exp_z, exp_ex);
    end
  endtask

  // driver: apply inputs, clock once, sample just after the edge
  task automatic drive(input logic r_i, input logic [2:0] op_i,
                       input logic [W-1:0] a_i, input logic [W-1:0] b_i);
    rst = r_i;
    op  = op_i;
    a   = a_i;
    b   = b_i;
    @(posedge clk);
    #1;
  endtask

  // independent reference model using plain SV arithmetic
  function automatic logic [W-1:0] model(input logic [2:0] op_i,
                                         input logic [W-1:0] a_i, input logic [W-1:0] b_i);
    logic [W-1:0] r;
    case (op_i)
      3'b000:  r = a_i & b_i;
      3'b001:  r = a_i | b_i;
      3'b010:  r = a_i + b_i;
      3'b110:  r = a_i - b_i;
      3'b111:  r = (a_i < b_i) ? 1 : 0;
      default: r = 0;
    endcase
    return r;
  endfunction

  initial begin
    logic [2:0] ops[5];
    logic [W:0] e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [2:0] rop;

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; op = 3'b000; a = '0; b = '0;
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b110; ops[4] = 3'b111;

    vecs[0]  = '{"reset_add",   1'b1, 3'b010, 32'd5,          32'd7,          32'h0000_0000, 1'b1};
    vecs[1]  = '{"and",         1'b0, 3'b000, 32'hF0F0_1234,  32'h0FF0_FFFF,  32'h00F0_1234, 1'b0};
    vecs[2]  = '{"or",          1'b0, 3'b001, 32'hF0F0_1234,  32'h0FF0_FFFF,  32'hFFF0_FFFF, 1'b0};
    vecs[3]  = '{"add_wrap",    1'b0, 3'b010, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 1'b1};
    vecs[4]  = '{"add",         1'b0, 3'b010, 32'd100,        32'd23,         32'd123,       1'b0};
    vecs[5]  = '{"sub",         1'b0, 3'b110, 32'd10,         32'd3,          32'd7,         1'b0};
    vecs[6]  = '{"sub_eq",      1'b0, 3'b110, 32'h1234_5678,  32'h1234_5678,  32'h0000_0000, 1'b1};
    vecs[7]  = '{"sub_wrap",    1'b0, 3'b110, 32'd0,          32'd1,          32'hFFFF_FFFF, 1'b0};
    vecs[8]  = '{"slt_msb_b",   1'b0, 3'b111, 32'd1,          32'h8000_0000,  32'd1,         1'b0};
    vecs[9]  = '{"slt_msb_a",   1'b0, 3'b111, 32'h8000_0000,  32'd1,          32'd0,         1'b1};
    vecs[10] = '{"slt_eq",      1'b0, 3'b111, 32'hDEAD_BEEF,  32'hDEAD_BEEF,  32'd0,         1'b1};
    vecs[11] = '{"undef_011",   1'b0, 3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,         1'b1};
    vecs[12] = '{"and_eq",      1'b0, 3'b000, 32'hA5A5_5A5A,  32'hA5A5_5A5A,  32'hA5A5_5A5A, 1'b0};
    vecs[13] = '{"undef_100",   1'b0, 3'b100, 32'h0000_00FF,  32'h0000_0F00,  32'd0,         1'b1};
    vecs[14] = '{"undef_101",   1'b0, 3'b101, 32'h0000_00FF,  32'h0000_0F00,  32'd0,         1'b1};
    vecs[15] = '{"slt_small",   1'b0, 3'b111, 32'd3,          32'd4,          32'd1,         1'b0};

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].op, vecs[i].a, vecs[i].b);
      check(vecs[i].name, vecs[i].exp_z, vecs[i].exp_ex);
    end

    // hold: unchanged inputs keep the output stable over several cycles
    drive(1'b0, 3'b001, 32'h0000_0F00, 32'h0000_00F0);
    check("hold_0", 32'h0000_0FF0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("hold_n", 32'h0000_0FF0, 1'b0);
    end

    // reset priority from a nonzero state discards the concurrent op
    drive(1'b1, 3'b001, 32'hFFFF_0000, 32'h0000_FFFF);
    check("reset_prio", 32'h0000_0000, 1'b1);
    drive(1'b0, 3'b001, 32'hFFFF_0000, 32'h0000_FFFF);
    check("after_reset", 32'hFFFF_FFFF, 1'b0);

    // back-to-back ops: each result appears one cycle after apply
    drive(1'b0, 3'b010, 32'd1, 32'd2);
    check("b2b_add", 32'd3, 1'b0);
    drive(1'b0, 3'b110, 32'd2, 32'd2);
    check("b2b_sub", 32'd0, 1'b1);
    drive(1'b0, 3'b111, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    check("b2b_slt", 32'd1, 1'b0);

    // random stimulus, half with a == b, through the scoreboard queue
    for (int i = 0; i < 60; i++) begin
      rop = ops[$urandom_range(0, 4)];
      ra  = $urandom;
      rb  = ($urandom_range(0, 1) == 1) ? ra : $urandom;
      e[W-1:0] = model(rop, ra, rb);
      e[W]     = (e[W-1:0] == '0);
      exp_q.push_back(e);
      drive(1'b0, rop, ra, rb);
      e = exp_q.pop_front();
      check("random", e[W-1:0], e[W]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
